// File: rtl/dial_decoder.sv
// ---------------------------------------------------------------------------
// dial_decoder
//   Front end for the safe's combination dial. Synchronises and debounces the
//   raw quadrature contacts, decodes detent steps and direction, keeps the
//   dial position and compares it with the combination digit chosen by
//   master_fsm.
//
// Ports
//   clk       in   1   system clock
//   rst       in   1   asynchronous reset, active-high
//   qa, qb    in   1   raw dial contacts A/B (asynchronous, bouncy)
//   clrCount  in   1   0 = synchronous clear of position/history, 1 = count
//   sel       in   2   digit selector (0..2, 3 = none)
//   pos       out  PW  current dial position (0..DIAL_MAX-1)
//   cnten     out  1   one-cycle pulse per accepted detent
//   up        out  1   direction of last detent (1 = CW)
//   dirch     out  1   pulse with cnten when the direction reversed
//   eq        out  1   pos == CODE[sel] (0 when sel = 3)
//   err       out  1   one-cycle pulse on an illegal quadrature transition
// ---------------------------------------------------------------------------
module dial_decoder #(
  parameter int DIAL_MAX = 100,
  parameter int PW       = 7,
  parameter int DEB_CYC  = 16,
  parameter int CODE0    = 12,
  parameter int CODE1    = 34,
  parameter int CODE2    = 56
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          qa,
  input  logic          qb,
  input  logic          clrCount,
  input  logic [1:0]    sel,
  output logic [PW-1:0] pos,
  output logic          cnten,
  output logic          up,
  output logic          dirch,
  output logic          eq,
  output logic          err
);

  localparam int            CW       = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(DIAL_MAX - 1);
  localparam bit            CODE0_OK = (CODE0 >= 0) && (CODE0 < DIAL_MAX);
  localparam bit            CODE1_OK = (CODE1 >= 0) && (CODE1 < DIAL_MAX);
  localparam bit            CODE2_OK = (CODE2 >= 0) && (CODE2 < DIAL_MAX);

  // Position of a {A,B} pair in the CW sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_phase = 2'd0;
      2'b10:   quad_phase = 2'd1;
      2'b11:   quad_phase = 2'd2;
      2'b01:   quad_phase = 2'd3;
      default: quad_phase = 2'd0;
    endcase
  endfunction

  // Index 1 = contact A, index 0 = contact B.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [CW-1:0] deb_cnt [2];
  logic [1:0]    ab_cur;
  logic [1:0]    ab_prev;
  logic [2:0]    sub;
  logic          stepped;

  logic [PW-1:0] pos_next;
  logic [2:0]    sub_next;
  logic          up_next;
  logic          stepped_next;
  logic          cnten_next;
  logic          dirch_next;
  logic          err_next;
  logic [1:0]    phase_diff;
  logic [3:0]    sub_sum;
  logic          moving;

  // Two-flop synchroniser for the raw contacts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {qa, qb};
      sync2 <= sync1;
    end
  end

  // Per-contact debouncer: the counter runs while the synced value differs
  // from the accepted one and restarts whenever they agree again, so any
  // bounce back restarts the stability window.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb[i]     <= 1'b0;
        deb_cnt[i] <= '0;
      end else if (sync2[i] == deb[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == CNT_LAST) begin
        deb[i]     <= sync2[i];
        deb_cnt[i] <= '0;
      end else begin
        deb_cnt[i] <= deb_cnt[i] + CW'(1);
      end
    end
  end

  // Registered debounced pair and its previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_cur  <= 2'b00;
      ab_prev <= 2'b00;
    end else begin
      ab_cur  <= deb;
      ab_prev <= ab_cur;
    end
  end

  // Step decode, detent accumulation, position update and clear.
  always_comb begin
    pos_next     = pos;
    sub_next     = sub;
    up_next      = up;
    stepped_next = stepped;
    cnten_next   = 1'b0;
    dirch_next   = 1'b0;
    err_next     = 1'b0;
    moving       = 1'b0;
    sub_sum      = {sub[2], sub};
    phase_diff   = quad_phase(ab_cur) - quad_phase(ab_prev);

    case (phase_diff)
      2'd1: begin
        moving  = 1'b1;
        sub_sum = {sub[2], sub} + 4'd1;
      end
      2'd3: begin
        moving  = 1'b1;
        sub_sum = {sub[2], sub} - 4'd1;
      end
      2'd2: begin
        err_next = 1'b1;
      end
      default: begin
        moving = 1'b0;
      end
    endcase

    if (moving && ((sub_sum == 4'b0100) || (sub_sum == 4'b1100))) begin
      // A full detent: +4 is CW, -4 is CCW.
      sub_next     = 3'b000;
      cnten_next   = 1'b1;
      up_next      = (sub_sum == 4'b0100);
      dirch_next   = stepped && (up_next != up);
      stepped_next = 1'b1;
      if (up_next) begin
        pos_next = (pos == POS_MAX) ? {PW{1'b0}} : pos + PW'(1);
      end else begin
        pos_next = (pos == {PW{1'b0}}) ? POS_MAX : pos - PW'(1);
      end
    end else if (moving) begin
      sub_next = sub_sum[2:0];
    end else begin
      sub_next = sub;
    end

    // Clear overrides any detent in the same cycle; direction is kept.
    if (!clrCount) begin
      pos_next     = {PW{1'b0}};
      sub_next     = 3'b000;
      stepped_next = 1'b0;
      up_next      = up;
      cnten_next   = 1'b0;
      dirch_next   = 1'b0;
    end else begin
      stepped_next = stepped_next;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= {PW{1'b0}};
      sub     <= 3'b000;
      up      <= 1'b0;
      stepped <= 1'b0;
      cnten   <= 1'b0;
      dirch   <= 1'b0;
      err     <= 1'b0;
    end else begin
      pos     <= pos_next;
      sub     <= sub_next;
      up      <= up_next;
      stepped <= stepped_next;
      cnten   <= cnten_next;
      dirch   <= dirch_next;
      err     <= err_next;
    end
  end

  // Combination digit match; out-of-range digits never match.
  always_comb begin
    case (sel)
      2'd0:    eq = CODE0_OK && (pos == PW'(CODE0));
      2'd1:    eq = CODE1_OK && (pos == PW'(CODE1));
      2'd2:    eq = CODE2_OK && (pos == PW'(CODE2));
      default: eq = 1'b0;
    endcase
  end

endmodule
